// File: rtl/dsa_csr_unit_if.sv
// CSR request/response bus between the instruction decoder and the DSA CSR bank.
interface dsa_csr_unit_if #(
  parameter int unsigned REG_WIDTH = 32
);
  logic                 csr_req;
  logic                 is_csr_read;
  logic [11:0]          csr_addr;
  logic [REG_WIDTH-1:0] csr_wdata;
  logic                 csr_ready;
  logic                 rdata_valid;
  logic                 rdata_ready;
  logic [REG_WIDTH-1:0] rdata;
  logic                 csr_err;

  modport master (
    output csr_req, is_csr_read, csr_addr, csr_wdata, rdata_ready,
    input  csr_ready, rdata_valid, rdata, csr_err
  );

  modport slave (
    input  csr_req, is_csr_read, csr_addr, csr_wdata, rdata_ready,
    output csr_ready, rdata_valid, rdata, csr_err
  );
endinterface

// File: rtl/dsa_csr_unit.sv
// Matrix-engine CSR bank: config registers, STATUS/done counter, shadow snapshot
// on calc_start, and a held read response over a valid/ready handshake.
module dsa_csr_unit #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned NUM_CSR   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  dsa_csr_unit_if.slave                    bus,
  input  logic                             calc_start,
  input  logic                             sa_busy,
  input  logic                             sa_done,
  output logic [(NUM_CSR-1)*REG_WIDTH-1:0] cfg_shadow
);

  localparam int unsigned NUM_CFG     = NUM_CSR - 1;
  localparam logic [11:0] STATUS_ADDR = 12'(NUM_CSR - 1);

  typedef enum logic {IDLE, RESP} state_t;

  state_t               state, state_nxt;
  logic [REG_WIDTH-1:0] cfg [NUM_CFG];
  logic [7:0]           done_count;
  logic [REG_WIDTH-1:0] rdata_q;
  logic [REG_WIDTH-1:0] rd_value;
  logic                 err_q;
  logic                 req_idle, rd_req, wr_req;
  logic                 addr_cfg, addr_status, addr_oor;

  // Requests arriving in RESP are ignored entirely
  assign req_idle    = bus.csr_req && (state == IDLE);
  assign rd_req      = req_idle && bus.is_csr_read;
  assign wr_req      = req_idle && !bus.is_csr_read;
  assign addr_cfg    = bus.csr_addr < STATUS_ADDR;
  assign addr_status = bus.csr_addr == STATUS_ADDR;
  assign addr_oor    = bus.csr_addr > STATUS_ADDR;

  always_comb begin
    rd_value = '0;
    if (addr_status) begin
      rd_value = REG_WIDTH'({done_count, 7'b0, sa_busy});
    end else if (addr_cfg) begin
      for (int unsigned i = 0; i < NUM_CFG; i++) begin
        if (bus.csr_addr == 12'(i)) rd_value = cfg[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rd_req) state_nxt = RESP;
      RESP: if (bus.rdata_ready) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (rd_req) rdata_q <= rd_value;
      err_q <= req_idle && addr_oor;
    end
  end

  // STATUS write clears first, then the same-cycle sa_done still counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_count <= '0;
    end else if (wr_req && addr_status) begin
      done_count <= 8'(sa_done);
    end else if (sa_done) begin
      done_count <= done_count + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CFG; i++) cfg[i] <= '0;
    end else if (wr_req && addr_cfg) begin
      for (int unsigned i = 0; i < NUM_CFG; i++) begin
        if (bus.csr_addr == 12'(i)) cfg[i] <= bus.csr_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_shadow <= '0;
    end else if (calc_start) begin
      for (int unsigned i = 0; i < NUM_CFG; i++) begin
        cfg_shadow[i*REG_WIDTH +: REG_WIDTH] <= cfg[i];
      end
    end
  end

  assign bus.csr_ready   = (state == IDLE) && !(bus.csr_req && bus.is_csr_read);
  assign bus.rdata_valid = (state == RESP);
  assign bus.rdata       = rdata_q;
  assign bus.csr_err     = err_q;

endmodule

// File: tb/tb_dsa_csr_unit.sv
// Self-checking bench for dsa_csr_unit: directed scenarios plus randomized traffic
// compared against an array-based register model.
module tb_dsa_csr_unit;
  localparam int RW   = 32;
  localparam int NC   = 16;
  localparam int NCFG = NC - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              calc_start, sa_busy, sa_done;
  logic [NCFG*RW-1:0] cfg_shadow;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] m_cfg    [NCFG];
  logic [RW-1:0] m_shadow [NCFG];
  int            m_done;

  dsa_csr_unit_if #(.REG_WIDTH(RW)) bus();

  dsa_csr_unit #(.REG_WIDTH(RW), .NUM_CSR(NC)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .calc_start (calc_start),
    .sa_busy    (sa_busy),
    .sa_done    (sa_done),
    .cfg_shadow (cfg_shadow)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] model_read(input logic [11:0] a);
    if (a < NCFG) return m_cfg[a];
    if (a == NCFG) return RW'((m_done % 256) * 256 + (sa_busy ? 1 : 0));
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCFG; i++) begin
      m_cfg[i]    = '0;
      m_shadow[i] = '0;
    end
    m_done = 0;
  endtask

  // One clock edge of architectural side effects, in the order the edge sees them
  task automatic model_edge(input bit wr, input logic [11:0] a, input logic [RW-1:0] d,
                            input bit calc, input bit done);
    if (calc) for (int i = 0; i < NCFG; i++) m_shadow[i] = m_cfg[i];
    if (wr && a < NCFG) m_cfg[a] = d;
    if (wr && a == NCFG) m_done = 0;
    if (done) m_done = (m_done + 1) % 256;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [RW-1:0] d, input bit calc,
                           input bit done, output bit err_after, output bit rdy_during);
    @(negedge clk);
    bus.csr_req = 1'b1; bus.is_csr_read = 1'b0; bus.csr_addr = a; bus.csr_wdata = d;
    calc_start = calc; sa_done = done;
    #1 rdy_during = bus.csr_ready;
    @(posedge clk);
    model_edge(1'b1, a, d, calc, done);
    #1;
    err_after = bus.csr_err;
    bus.csr_req = 1'b0; calc_start = 1'b0; sa_done = 1'b0;
  endtask

  task automatic pulse(input bit calc, input bit done);
    @(negedge clk);
    calc_start = calc; sa_done = done;
    @(posedge clk);
    model_edge(1'b0, 12'h0, '0, calc, done);
    #1;
    calc_start = 1'b0; sa_done = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, input int stall, output logic [RW-1:0] data,
                          output bit rdy_req, output bit valid_first, output bit stable,
                          output bit released, output bit err_after, output bit err_next);
    @(negedge clk);
    bus.csr_req = 1'b1; bus.is_csr_read = 1'b1; bus.csr_addr = a;
    bus.rdata_ready = (stall == 0);
    #1 rdy_req = bus.csr_ready;
    @(posedge clk); #1;
    bus.csr_req = 1'b0;
    valid_first = bus.rdata_valid;
    data        = bus.rdata;
    err_after   = bus.csr_err;
    stable      = 1'b1;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      if (!(bus.rdata_valid && bus.rdata == data && !bus.csr_ready)) stable = 1'b0;
    end
    bus.rdata_ready = 1'b1;
    @(posedge clk); #1;
    released = !bus.rdata_valid && bus.csr_ready;
    err_next = bus.csr_err;
    bus.rdata_ready = 1'b0;
  endtask

  function automatic bit shadow_matches();
    for (int i = 0; i < NCFG; i++)
      if (cfg_shadow[i*RW +: RW] !== m_shadow[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.csr_req = 1'b0; bus.is_csr_read = 1'b0; bus.csr_addr = '0; bus.csr_wdata = '0;
    bus.rdata_ready = 1'b0; calc_start = 1'b0; sa_busy = 1'b0; sa_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.rdata_valid !== 1'b0 || bus.csr_err !== 1'b0 || bus.rdata !== '0 || bus.csr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b err=%b rdata=%h ready=%b, required 0 0 0 1",
               bus.rdata_valid, bus.csr_err, bus.rdata, bus.csr_ready);
    end
    checks++;
    if (cfg_shadow !== '0) begin
      errors++;
      $display("FAIL reset_shadow: got %h, required 0", cfg_shadow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [RW-1:0] d; bit e, r, v, s, rel, en;
    bus_write(12'h003, 32'hDEADBEEF, 1'b0, 1'b0, e, r);
    checks++;
    if (e !== 1'b0 || r !== 1'b1) begin
      errors++; $display("FAIL wr_basic: err=%b ready=%b, required 0 1", e, r);
    end
    bus_read(12'h003, 0, d, r, v, s, rel, e, en);
    checks++;
    if (d !== 32'hDEADBEEF || v !== 1'b1) begin
      errors++; $display("FAIL rd_basic: data=%h valid=%b, required deadbeef 1", d, v);
    end
    checks++;
    if (r !== 1'b0 || rel !== 1'b1) begin
      errors++; $display("FAIL rd_ready: ready_in_req=%b released=%b, required 0 1", r, rel);
    end
  endtask

  task automatic test_read_stall();
    logic [RW-1:0] d, w; bit e, r, v, s, rel, en;
    w = $urandom;
    bus_write(12'h001, w, 1'b0, 1'b0, e, r);
    bus_read(12'h001, 5, d, r, v, s, rel, e, en);
    checks++;
    if (d !== w || v !== 1'b1 || s !== 1'b1) begin
      errors++; $display("FAIL rd_stall: data=%h valid=%b stable=%b, required %h 1 1", d, v, s, w);
    end
    checks++;
    if (rel !== 1'b1) begin
      errors++; $display("FAIL rd_stall_release: released=%b, required 1", rel);
    end
  endtask

  task automatic test_shadow();
    logic [RW-1:0] d; bit e, r, v, s, rel, en;
    bus_write(12'h002, 32'h11, 1'b0, 1'b0, e, r);
    bus_write(12'h002, 32'h22, 1'b1, 1'b0, e, r);
    checks++;
    if (cfg_shadow[2*RW +: RW] !== 32'h11 || !shadow_matches()) begin
      errors++; $display("FAIL shadow_prewrite: reg2=%h, required 11", cfg_shadow[2*RW +: RW]);
    end
    bus_read(12'h002, 0, d, r, v, s, rel, e, en);
    checks++;
    if (d !== 32'h22) begin
      errors++; $display("FAIL shadow_cfg_new: data=%h, required 22", d);
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (cfg_shadow[2*RW +: RW] !== 32'h22 || !shadow_matches()) begin
      errors++; $display("FAIL shadow_reload: reg2=%h, required 22", cfg_shadow[2*RW +: RW]);
    end
  endtask

  task automatic test_status();
    logic [RW-1:0] d; bit e, r, v, s, rel, en;
    sa_busy = 1'b1;
    bus_write(12'h00F, $urandom, 1'b0, 1'b0, e, r);
    repeat (3) pulse(1'b0, 1'b1);
    bus_read(12'h00F, 0, d, r, v, s, rel, e, en);
    checks++;
    if (d !== 32'h0000_0301 || d !== model_read(12'h00F)) begin
      errors++; $display("FAIL status_count: data=%h, required 00000301", d);
    end
    bus_write(12'h00F, 32'hFFFF_FFFF, 1'b0, 1'b1, e, r);
    bus_read(12'h00F, 0, d, r, v, s, rel, e, en);
    checks++;
    if (d !== 32'h0000_0101) begin
      errors++; $display("FAIL status_clear_count: data=%h, required 00000101", d);
    end
    sa_busy = 1'b0;
    bus_read(12'h00F, 0, d, r, v, s, rel, e, en);
    checks++;
    if (d !== 32'h0000_0100) begin
      errors++; $display("FAIL status_idle: data=%h, required 00000100", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [RW-1:0] d; bit e, r, v, s, rel, en;
    bus_write(12'h040, 32'hA5A5_A5A5, 1'b0, 1'b0, e, r);
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL oor_wr_err: err=%b, required 1", e);
    end
    bus_read(12'h040, 2, d, r, v, s, rel, e, en);
    checks++;
    if (d !== '0 || v !== 1'b1 || e !== 1'b1 || en !== 1'b0 || rel !== 1'b1) begin
      errors++; $display("FAIL oor_rd: data=%h valid=%b err=%b err_later=%b rel=%b, required 0 1 1 0 1",
                         d, v, e, en, rel);
    end
    bus_read(12'hFFF, 0, d, r, v, s, rel, e, en);
    checks++;
    if (d !== '0 || e !== 1'b1 || en !== 1'b0) begin
      errors++; $display("FAIL oor_rd_top: data=%h err=%b err_later=%b, required 0 1 0", d, e, en);
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (!shadow_matches()) begin
      errors++; $display("FAIL oor_no_change: shadow=%h differs from model", cfg_shadow);
    end
  endtask

  task automatic test_random();
    logic [RW-1:0] d, w, exp; logic [11:0] a; bit e, r, v, s, rel, en, c, dn;
    int op, sel, bad;
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      op  = $urandom_range(0, 9);
      sel = $urandom_range(0, 9);
      a   = (sel < 7) ? 12'($urandom_range(0, NCFG-1)) :
            (sel == 7) ? 12'(NCFG) : 12'($urandom_range(NC, 4095));
      sa_busy = 1'($urandom);
      if (op < 4) begin
        w = $urandom; c = ($urandom_range(0, 7) == 0); dn = ($urandom_range(0, 3) == 0);
        bus_write(a, w, c, dn, e, r);
        checks++;
        if (e !== (a >= NC) || r !== 1'b1) begin
          errors++; bad++;
          $display("FAIL rnd_wr: addr=%h err=%b ready=%b, required %b 1", a, e, r, a >= NC);
        end
      end else if (op < 8) begin
        exp = model_read(a);
        bus_read(a, $urandom_range(0, 2), d, r, v, s, rel, e, en);
        checks++;
        if (d !== exp || v !== 1'b1 || s !== 1'b1 || rel !== 1'b1 || e !== (a >= NC)) begin
          errors++; bad++;
          $display("FAIL rnd_rd: addr=%h data=%h err=%b, required %h %b", a, d, e, exp, a >= NC);
        end
      end else begin
        pulse(1'($urandom), 1'($urandom));
      end
      if (bad > 10) break;
    end
    checks++;
    if (!shadow_matches()) begin
      errors++; $display("FAIL rnd_shadow: shadow=%h differs from model", cfg_shadow);
    end
  endtask

  task automatic test_reset_in_resp();
    logic [RW-1:0] d; bit e, r, v, s, rel, en, all_zero;
    bus_write(12'h005, 32'h1234_5678, 1'b1, 1'b0, e, r);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    bus.csr_req = 1'b1; bus.is_csr_read = 1'b1; bus.csr_addr = 12'h005; bus.rdata_ready = 1'b0;
    @(posedge clk); #1;
    bus.csr_req = 1'b0;
    checks++;
    if (bus.rdata_valid !== 1'b1) begin
      errors++; $display("FAIL rst_resp_pre: valid=%b, required 1", bus.rdata_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.rdata_valid !== 1'b0) begin
      errors++; $display("FAIL rst_resp_drop: valid=%b, required 0", bus.rdata_valid);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.csr_ready !== 1'b1 || cfg_shadow !== '0 || bus.rdata_valid !== 1'b0) begin
      errors++; $display("FAIL rst_resp_after: ready=%b valid=%b shadow=%h, required 1 0 0",
                         bus.csr_ready, bus.rdata_valid, cfg_shadow);
    end
    all_zero = 1'b1;
    for (int i = 0; i < NCFG; i++) begin
      bus_read(12'(i), 0, d, r, v, s, rel, e, en);
      if (d !== '0) all_zero = 1'b0;
    end
    checks++;
    if (all_zero !== 1'b1) begin
      errors++; $display("FAIL rst_cfg_zero: some register nonzero, required all 0");
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_stall();
    test_shadow();
    test_status();
    test_out_of_range();
    test_random();
    test_reset_in_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
